// File: rtl/complex_pkg.sv
// Shared definitions for the complex multiply-accumulate datapath.
//   PROD_W / PART_W : width of a packed complex product and of each component
//   RE_* / IM_*     : bit positions of the real and imaginary fields in a product
//   state_t         : accumulator FSM states
package complex_pkg;
  localparam int PROD_W = 34;
  localparam int PART_W = 17;
  localparam int RE_MSB = 33;
  localparam int RE_LSB = 17;
  localparam int IM_MSB = 16;
  localparam int IM_LSB = 0;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;
endpackage

// File: rtl/complex_accumulator_if.sv
// Streaming bus of the complex accumulator: product input channel and
// frame-sum output channel.
//   InValid/InProduct/InReady             : term channel, {re[16:0], im[16:0]}
//   OutValid/OutReal/OutImag/OutOverflow  : result channel
//   OutReady                              : consumer accepts the result
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high; while valid is high and ready is low the
// source holds its data unchanged. Ready may depend on state, never on valid.
// slave  : the accumulator side.
// master : the producer/consumer side.
interface complex_accumulator_if #(
  parameter int ACC_W = 24
);
  logic                              InValid;
  logic [complex_pkg::PROD_W-1:0]    InProduct;
  logic                              InReady;
  logic                              OutValid;
  logic                              OutReady;
  logic signed [ACC_W-1:0]           OutReal;
  logic signed [ACC_W-1:0]           OutImag;
  logic                              OutOverflow;

  modport slave (
    input  InValid, InProduct, OutReady,
    output InReady, OutValid, OutReal, OutImag, OutOverflow
  );

  modport master (
    output InValid, InProduct, OutReady,
    input  InReady, OutValid, OutReal, OutImag, OutOverflow
  );
endinterface

// File: rtl/complex_sat_add.sv
// One component of the complex accumulator: adds a sign-extended 17-bit term
// to a signed ACC_W accumulator and clamps the result to the ACC_W range.
//   i_acc      : current accumulator value
//   i_term     : 17-bit two's complement term
//   i_zero_acc : treat the accumulator as zero (first term of a frame)
//   o_sum      : saturated sum
//   o_sat      : the sum was clamped
module complex_sat_add
  import complex_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic        [PART_W-1:0] i_term,
  input  logic                     i_zero_acc,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic                     o_sat
);
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_acc_x;
  logic [ACC_W:0] w_term_x;
  logic [ACC_W:0] w_sum;

  always_comb begin
    w_acc_x  = i_zero_acc ? '0 : {i_acc[ACC_W-1], i_acc};
    w_term_x = {{(ACC_W+1-PART_W){i_term[PART_W-1]}}, i_term};
    w_sum    = w_acc_x + w_term_x;
    o_sat    = 1'b0;
    o_sum    = w_sum[ACC_W-1:0];
    // One guard bit is enough: the two top bits disagree only on overflow,
    // and the guard bit carries the true sign.
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
      o_sat = 1'b1;
      o_sum = w_sum[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end
endmodule

// File: rtl/complex_accumulator.sv
// Complex dot-product accumulator. Sums N_TERMS complex products per frame
// with per-addition saturation and presents one result per frame.
//   Clk, Reset : clock and synchronous active-high reset
//   Clear      : synchronous abort of the current frame (drops a held result)
//   bus        : product input and result output channels (slave side)
//   o_state    : current FSM state, for observation
// In ACCUM terms are accepted; the last term of a frame moves to HOLD, where
// the result is presented until the consumer takes it. One bubble per frame.
module complex_accumulator
  import complex_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 24
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   Clear,
  complex_accumulator_if.slave bus,
  output state_t o_state
);
  localparam int               CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_count;
  logic signed [ACC_W-1:0] r_acc_re;
  logic signed [ACC_W-1:0] r_acc_im;
  logic                    r_ovf;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_real;
  logic signed [ACC_W-1:0] r_out_imag;
  logic                    r_out_ovf;

  logic                    w_accept;
  logic                    w_last;
  logic                    w_zero_acc;
  logic signed [ACC_W-1:0] w_sum_re;
  logic signed [ACC_W-1:0] w_sum_im;
  logic                    w_sat_re;
  logic                    w_sat_im;

  // The accumulator is already zero at a frame start; the flag keeps the
  // first term independent of whatever the acc registers hold.
  assign w_zero_acc = (r_count == '0);

  complex_sat_add #(.ACC_W(ACC_W)) u_add_re (
    .i_acc      (r_acc_re),
    .i_term     (bus.InProduct[RE_MSB:RE_LSB]),
    .i_zero_acc (w_zero_acc),
    .o_sum      (w_sum_re),
    .o_sat      (w_sat_re)
  );

  complex_sat_add #(.ACC_W(ACC_W)) u_add_im (
    .i_acc      (r_acc_im),
    .i_term     (bus.InProduct[IM_MSB:IM_LSB]),
    .i_zero_acc (w_zero_acc),
    .o_sum      (w_sum_im),
    .o_sat      (w_sat_im)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      ACCUM: begin
        w_accept = bus.InValid;
        w_last   = (r_count == LAST);
        if (w_accept && w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.OutReady) w_state_nxt = ACCUM;
      end
    endcase
    if (Clear) w_state_nxt = ACCUM;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ACCUM;
      r_count     <= '0;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_real  <= '0;
      r_out_imag  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (Clear) begin
      r_state  <= w_state_nxt;
      r_count  <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_ovf    <= 1'b0;
      if (r_state == HOLD) begin
        r_out_valid <= 1'b0;
        r_out_real  <= '0;
        r_out_imag  <= '0;
        r_out_ovf   <= 1'b0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_last) begin
          r_out_real  <= w_sum_re;
          r_out_imag  <= w_sum_im;
          r_out_ovf   <= r_ovf | w_sat_re | w_sat_im;
          r_out_valid <= 1'b1;
          r_count     <= '0;
          r_acc_re    <= '0;
          r_acc_im    <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
          r_count  <= r_count + CNT_W'(1);
          r_ovf    <= r_ovf | w_sat_re | w_sat_im;
        end
      end
      if ((r_state == HOLD) && bus.OutReady) r_out_valid <= 1'b0;
    end
  end

  assign bus.InReady     = (r_state == ACCUM);
  assign bus.OutValid    = r_out_valid;
  assign bus.OutReal     = r_out_real;
  assign bus.OutImag     = r_out_imag;
  assign bus.OutOverflow = r_out_ovf;
  assign o_state         = r_state;
endmodule

// File: tb/tb_complex_accumulator.sv
module tb_complex_accumulator;
  import complex_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  logic Clear;
  always #5 Clk = ~Clk;

  // Instance 0: N_TERMS=4, ACC_W=24. Instance 1: N_TERMS=8, ACC_W=18.
  complex_accumulator_if #(.ACC_W(24)) if_a ();
  complex_accumulator_if #(.ACC_W(18)) if_b ();
  state_t state_a;
  state_t state_b;

  complex_accumulator #(.N_TERMS(4), .ACC_W(24)) dut_a (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .bus(if_a.slave), .o_state(state_a)
  );
  complex_accumulator #(.N_TERMS(8), .ACC_W(18)) dut_b (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .bus(if_b.slave), .o_state(state_b)
  );

  logic        in_valid [2];
  logic [33:0] in_prod  [2];
  logic        out_ready[2];
  logic        in_ready [2];
  logic        o_valid  [2];
  logic        o_ovf    [2];
  logic [23:0] o_re     [2];
  logic [23:0] o_im     [2];

  assign if_a.InValid   = in_valid[0];
  assign if_a.InProduct = in_prod[0];
  assign if_a.OutReady  = out_ready[0];
  assign if_b.InValid   = in_valid[1];
  assign if_b.InProduct = in_prod[1];
  assign if_b.OutReady  = out_ready[1];
  assign in_ready[0] = if_a.InReady;
  assign in_ready[1] = if_b.InReady;
  assign o_valid[0]  = if_a.OutValid;
  assign o_valid[1]  = if_b.OutValid;
  assign o_ovf[0]    = if_a.OutOverflow;
  assign o_ovf[1]    = if_b.OutOverflow;
  assign o_re[0]     = if_a.OutReal;
  assign o_im[0]     = if_a.OutImag;
  assign o_re[1]     = {{6{if_b.OutReal[17]}}, if_b.OutReal};
  assign o_im[1]     = {{6{if_b.OutImag[17]}}, if_b.OutImag};

  // ---------------- reference model / scoreboard ----------------
  int          acc_w[2] = '{24, 18};
  logic [33:0] frame_q[$];
  logic [48:0] exp_q[$];   // {ovf, re[23:0], im[23:0]}
  int          total = 0;
  int          bad   = 0;

  // Frame sum from the arithmetic rules: running sum clamped after every add.
  function automatic void model_frame(input int d);
    longint      hi, lo, re, im;
    bit          ovf;
    logic [16:0] p_re, p_im;
    hi  = (longint'(1) <<< (acc_w[d] - 1)) - 1;
    lo  = -hi - 1;
    re  = 0;
    im  = 0;
    ovf = 1'b0;
    foreach (frame_q[i]) begin
      p_re = frame_q[i][33:17];
      p_im = frame_q[i][16:0];
      re = re + longint'($signed(p_re));
      im = im + longint'($signed(p_im));
      if (re > hi) begin re = hi; ovf = 1'b1; end
      else if (re < lo) begin re = lo; ovf = 1'b1; end
      if (im > hi) begin im = hi; ovf = 1'b1; end
      else if (im < lo) begin im = lo; ovf = 1'b1; end
    end
    exp_q.push_back({ovf, 24'(re), 24'(im)});
  endfunction

  function automatic logic [33:0] mk_term(input int re, input int im);
    logic [16:0] r, i;
    r = 17'(re);
    i = 17'(im);
    return {r, i};
  endfunction

  function automatic logic [33:0] rand_term();
    return {17'($urandom_range(131071, 0)), 17'($urandom_range(131071, 0))};
  endfunction

  // ---------------- driver tasks (all start and end on a falling edge) ----------------
  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_ready(input int d, output bit to);
    int c;
    c  = 0;
    to = 1'b0;
    while (in_ready[d] !== 1'b1) begin
      @(negedge Clk);
      c++;
      if (c > 50) begin to = 1'b1; break; end
    end
  endtask

  // Presents every term of frame_q in order; returns on the falling edge
  // right after the last term was accepted.
  task automatic drive_frame(input int d, input int gap_max, output bit to);
    int g;
    to = 1'b0;
    foreach (frame_q[i]) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) @(negedge Clk);
      in_valid[d] = 1'b1;
      in_prod[d]  = frame_q[i];
      wait_ready(d, to);
      if (to) break;
      @(negedge Clk);
      in_valid[d] = 1'b0;
    end
    in_valid[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    Clear = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_prod[d] = '0; out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({o_valid[d], o_ovf[d], o_re[d], o_im[d]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d got valid=%0b ovf=%0b re=%0d im=%0d exp all 0",
                 d, o_valid[d], o_ovf[d], $signed(o_re[d]), $signed(o_im[d]));
      end
      total++;
      if (in_ready[d] !== 1'b1) begin
        bad++; $display("FAIL reset_in_ready dut%0d got=%0b exp=1", d, in_ready[d]);
      end
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    logic [48:0] e;
    frame_q = {};
    repeat (4) frame_q.push_back(mk_term(3, -2));
    model_frame(0);
    e = exp_q.pop_front();
    out_ready[0] = 1'b1;
    drive_frame(0, 0, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=timeout exp=accept"); end
    total++;
    if (o_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      bad++; $display("FAIL basic_latency got valid=%0b ready=%0b exp valid=1 ready=0", o_valid[0], in_ready[0]);
    end
    total++;
    if ({o_ovf[0], o_re[0], o_im[0]} !== e || e !== {1'b0, 24'd12, -24'sd8}) begin
      bad++; $display("FAIL basic_sum got re=%0d im=%0d ovf=%0b exp re=12 im=-8 ovf=0",
                      $signed(o_re[0]), $signed(o_im[0]), o_ovf[0]);
    end
    @(negedge Clk);
    total++;
    if (o_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL basic_bubble got valid=%0b ready=%0b exp valid=0 ready=1", o_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [48:0] e;
    frame_q = {};
    repeat (4) frame_q.push_back(mk_term(3, -2));
    model_frame(0);
    e = exp_q.pop_front();
    out_ready[0] = 1'b0;
    drive_frame(0, 0, to);
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout got=timeout exp=accept"); end
    // Next frame's first term is presented and held during HOLD.
    frame_q = {};
    repeat (4) frame_q.push_back(rand_term());
    model_frame(0);
    in_valid[0] = 1'b1;
    in_prod[0]  = frame_q[0];
    for (int c = 0; c < 5; c++) begin
      total++;
      if (o_valid[0] !== 1'b1 || {o_ovf[0], o_re[0], o_im[0]} !== e) begin
        bad++; $display("FAIL bp_stable cyc%0d got valid=%0b re=%0d im=%0d exp valid=1 re=12 im=-8",
                        c, o_valid[0], $signed(o_re[0]), $signed(o_im[0]));
      end
      total++;
      if (in_ready[0] !== 1'b0 || state_a !== HOLD) begin
        bad++; $display("FAIL bp_in_ready cyc%0d got ready=%0b state=%0d exp ready=0 state=HOLD",
                        c, in_ready[0], state_a);
      end
      @(negedge Clk);
    end
    out_ready[0] = 1'b1;
    @(negedge Clk);
    total++;
    if (o_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL bp_release got valid=%0b ready=%0b exp valid=0 ready=1", o_valid[0], in_ready[0]);
    end
    @(negedge Clk);            // held term accepted on this edge
    in_valid[0] = 1'b0;
    void'(frame_q.pop_front());
    drive_frame(0, 0, to);
    e = exp_q.pop_front();
    total++;
    if (to || o_valid[0] !== 1'b1 || {o_ovf[0], o_re[0], o_im[0]} !== e) begin
      bad++; $display("FAIL bp_next_frame got valid=%0b re=%0d im=%0d exp re=%0d im=%0d",
                      o_valid[0], $signed(o_re[0]), $signed(o_im[0]), $signed(e[47:24]), $signed(e[23:0]));
    end
  endtask

  task automatic test_gapped();
    bit to;
    logic [48:0] e;
    frame_q = {};
    for (int k = 1; k <= 4; k++) frame_q.push_back(mk_term(k, 0));
    model_frame(0);
    e = exp_q.pop_front();
    out_ready[0] = 1'b1;
    @(negedge Clk);
    drive_frame(0, 3, to);
    total++;
    if (to || o_valid[0] !== 1'b1 || {o_ovf[0], o_re[0], o_im[0]} !== e || e[47:24] !== 24'd10) begin
      bad++; $display("FAIL gapped_sum got valid=%0b re=%0d im=%0d exp re=10 im=0",
                      o_valid[0], $signed(o_re[0]), $signed(o_im[0]));
    end
  endtask

  task automatic test_clear();
    bit to;
    logic [48:0] e;
    @(negedge Clk);
    frame_q = {};
    repeat (2) frame_q.push_back(rand_term());
    drive_frame(0, 0, to);
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    frame_q = {};
    repeat (4) frame_q.push_back(mk_term(1, 1));
    model_frame(0);
    e = exp_q.pop_front();
    drive_frame(0, 1, to);
    total++;
    if (to || o_valid[0] !== 1'b1 || {o_ovf[0], o_re[0], o_im[0]} !== e) begin
      bad++; $display("FAIL clear_accum got valid=%0b re=%0d im=%0d exp re=4 im=4",
                      o_valid[0], $signed(o_re[0]), $signed(o_im[0]));
    end
    // Clear while a result is held.
    @(negedge Clk);
    out_ready[0] = 1'b0;
    frame_q = {};
    repeat (4) frame_q.push_back(rand_term());
    drive_frame(0, 0, to);
    total++;
    if (to || o_valid[0] !== 1'b1) begin
      bad++; $display("FAIL clear_hold_setup got valid=%0b exp=1", o_valid[0]);
    end
    Clear = 1'b1;
    @(negedge Clk);
    Clear = 1'b0;
    total++;
    if (o_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || {o_ovf[0], o_re[0], o_im[0]} !== '0) begin
      bad++; $display("FAIL clear_hold got valid=%0b ready=%0b re=%0d im=%0d exp valid=0 ready=1 re=0 im=0",
                      o_valid[0], in_ready[0], $signed(o_re[0]), $signed(o_im[0]));
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [48:0] e;
    out_ready[0] = 1'b0;
    frame_q = {};
    repeat (4) frame_q.push_back(rand_term());
    drive_frame(0, 0, to);
    pulse_reset();
    total++;
    if (o_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || {o_ovf[0], o_re[0], o_im[0]} !== '0) begin
      bad++; $display("FAIL reset_hold got valid=%0b ready=%0b re=%0d exp valid=0 ready=1 re=0",
                      o_valid[0], in_ready[0], $signed(o_re[0]));
    end
    frame_q = {};
    repeat (3) frame_q.push_back(rand_term());
    drive_frame(0, 0, to);
    pulse_reset();
    total++;
    if (o_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL reset_accum got valid=%0b ready=%0b exp valid=0 ready=1", o_valid[0], in_ready[0]);
    end
    out_ready[0] = 1'b1;
    frame_q = {};
    repeat (4) frame_q.push_back(rand_term());
    model_frame(0);
    e = exp_q.pop_front();
    drive_frame(0, 0, to);
    total++;
    if (to || o_valid[0] !== 1'b1 || {o_ovf[0], o_re[0], o_im[0]} !== e) begin
      bad++; $display("FAIL reset_restart got valid=%0b re=%0d im=%0d exp re=%0d im=%0d",
                      o_valid[0], $signed(o_re[0]), $signed(o_im[0]), $signed(e[47:24]), $signed(e[23:0]));
    end
  endtask

  task automatic test_saturation();
    bit to;
    logic [48:0] e;
    out_ready[1] = 1'b1;
    frame_q = {};
    repeat (8) frame_q.push_back(mk_term(32767, -32768));
    model_frame(1);
    e = exp_q.pop_front();
    drive_frame(1, 0, to);
    total++;
    if (to || o_valid[1] !== 1'b1 || {o_ovf[1], o_re[1], o_im[1]} !== e
        || e !== {1'b1, 24'sd131071, -24'sd131072}) begin
      bad++; $display("FAIL sat_clamp got valid=%0b re=%0d im=%0d ovf=%0b exp re=131071 im=-131072 ovf=1",
                      o_valid[1], $signed(o_re[1]), $signed(o_im[1]), o_ovf[1]);
    end
    frame_q = {};
    repeat (8) frame_q.push_back('0);
    model_frame(1);
    e = exp_q.pop_front();
    drive_frame(1, 0, to);
    total++;
    if (to || o_valid[1] !== 1'b1 || {o_ovf[1], o_re[1], o_im[1]} !== e) begin
      bad++; $display("FAIL sat_zero_frame got re=%0d im=%0d ovf=%0b exp re=0 im=0 ovf=0",
                      $signed(o_re[1]), $signed(o_im[1]), o_ovf[1]);
    end
  endtask

  task automatic test_random(input int d, input int frames, input int n);
    bit to;
    logic [48:0] e;
    out_ready[d] = 1'b1;
    for (int f = 0; f < frames; f++) begin
      frame_q = {};
      repeat (n) frame_q.push_back(rand_term());
      model_frame(d);
      e = exp_q.pop_front();
      drive_frame(d, 2, to);
      total++;
      if (to || o_valid[d] !== 1'b1 || {o_ovf[d], o_re[d], o_im[d]} !== e) begin
        bad++; $display("FAIL random dut%0d frame%0d got valid=%0b re=%0d im=%0d ovf=%0b exp re=%0d im=%0d ovf=%0b",
                        d, f, o_valid[d], $signed(o_re[d]), $signed(o_im[d]), o_ovf[d],
                        $signed(e[47:24]), $signed(e[23:0]), e[48]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_clear();
    test_reset_mid();
    test_saturation();
    test_random(0, 6, 4);
    test_random(1, 8, 8);
    repeat (2) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a stimulus loop never returns.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
